// File: rtl/control_pkg.sv
// control_pkg: shared ALU op codes, opcodes, FSM states and source-select encodings
package control_pkg;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_XOR  = 4'b1000;
  localparam logic [3:0] ALU_SUB  = 4'b1010;
  localparam logic [3:0] ALU_GE   = 4'b1100;
  localparam logic [3:0] ALU_GEU  = 4'b1101;
  localparam logic [3:0] ALU_SLT  = 4'b1110;
  localparam logic [3:0] ALU_SLTU = 4'b1111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  typedef logic [3:0] state_t;
  localparam state_t S_FETCH    = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_MEMADR   = 4'd2;
  localparam state_t S_MEMREAD  = 4'd3;
  localparam state_t S_MEMWB    = 4'd4;
  localparam state_t S_MEMWRITE = 4'd5;
  localparam state_t S_EXECR    = 4'd6;
  localparam state_t S_EXECI    = 4'd7;
  localparam state_t S_ALUWB    = 4'd8;
  localparam state_t S_BRANCH   = 4'd9;
  localparam state_t S_JAL      = 4'd10;
  localparam state_t S_JALR     = 4'd11;
  localparam state_t S_LINK     = 4'd12;
  localparam state_t S_LUI      = 4'd13;
  localparam state_t S_AUIPC    = 4'd14;
  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_RS1   = 2'b01;
  localparam logic [1:0] SRC_A_OLDPC = 2'b10;
  localparam logic [1:0] SRC_A_ZERO  = 2'b11;
  localparam logic [1:0] SRC_B_RS2   = 2'b00;
  localparam logic [1:0] SRC_B_FOUR  = 2'b01;
  localparam logic [1:0] SRC_B_IMM   = 2'b10;
  localparam logic PCSRC_ALU    = 1'b0;
  localparam logic PCSRC_ALUOUT = 1'b1;
  localparam logic [1:0] AC_R  = 2'd0;
  localparam logic [1:0] AC_I  = 2'd1;
  localparam logic [1:0] AC_BR = 2'd2;
endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: instruction fields and flags in, datapath control strobes/selects out
interface control_unit_if;
  logic [6:0] OPCODE_i;
  logic [2:0] FUNCT3_i;
  logic [6:0] FUNCT7_i;
  logic       ALU_ZR_i;
  logic       PC_WRITE_o;
  logic       IORD_o;
  logic       MEM_READ_o;
  logic       MEM_WRITE_o;
  logic       IR_WRITE_o;
  logic       MEM_TO_REG_o;
  logic       REG_WRITE_o;
  logic [1:0] ALU_SRC_A_o;
  logic [1:0] ALU_SRC_B_o;
  logic       PC_SOURCE_o;
  logic [3:0] ALU_OP_o;
  modport master (
    input  OPCODE_i, FUNCT3_i, FUNCT7_i, ALU_ZR_i,
    output PC_WRITE_o, IORD_o, MEM_READ_o, MEM_WRITE_o, IR_WRITE_o, MEM_TO_REG_o,
           REG_WRITE_o, ALU_SRC_A_o, ALU_SRC_B_o, PC_SOURCE_o, ALU_OP_o
  );
  modport slave (
    output OPCODE_i, FUNCT3_i, FUNCT7_i, ALU_ZR_i,
    input  PC_WRITE_o, IORD_o, MEM_READ_o, MEM_WRITE_o, IR_WRITE_o, MEM_TO_REG_o,
           REG_WRITE_o, ALU_SRC_A_o, ALU_SRC_B_o, PC_SOURCE_o, ALU_OP_o
  );
endinterface

// File: rtl/alu_control.sv
// alu_control: funct3/funct7[5] to ALU op for R-type, I-type and branch, plus branch-taken
module alu_control
  import control_pkg::*;
(
  input  logic [1:0] mode,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  input  logic       zero,
  output logic [3:0] alu_op,
  output logic       taken
);
  always_comb begin
    alu_op = ALU_ADD;
    taken  = 1'b0;
    if (mode == AC_BR) begin
      case (funct3)
        3'b000: begin alu_op = ALU_SUB;  taken = zero;  end
        3'b001: begin alu_op = ALU_SUB;  taken = !zero; end
        3'b100: begin alu_op = ALU_SLT;  taken = !zero; end
        3'b101: begin alu_op = ALU_GE;   taken = !zero; end
        3'b110: begin alu_op = ALU_SLTU; taken = !zero; end
        3'b111: begin alu_op = ALU_GEU;  taken = !zero; end
        default: ;
      endcase
    end else begin
      case (funct3)
        3'b000: alu_op = (mode == AC_R && funct7_b5) ? ALU_SUB : ALU_ADD;
        3'b001: alu_op = ALU_SLL;
        3'b010: alu_op = ALU_SLT;
        3'b011: alu_op = ALU_SLTU;
        3'b100: alu_op = ALU_XOR;
        3'b101: alu_op = funct7_b5 ? ALU_SRA : ALU_SRL;
        3'b110: alu_op = ALU_OR;
        default: alu_op = ALU_AND;
      endcase
    end
  end
endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle RV32I control FSM driving datapath strobes and selects
module control_unit
  import control_pkg::*;
(
  input  logic CLK_i,
  input  logic RST_i,
  control_unit_if.master bus
);
  state_t state_q, state_d;
  logic pc_write, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_write, pc_source;
  logic [1:0] src_a, src_b, ac_mode;
  logic [3:0] alu_op, ac_op;
  logic ac_taken;
  logic unused_f7;
  assign unused_f7 = ^{bus.FUNCT7_i[6], bus.FUNCT7_i[4:0]};
  assign ac_mode = state_q == S_EXECI ? AC_I : state_q == S_BRANCH ? AC_BR : AC_R;
  alu_control u_alu_control (
    .mode(ac_mode), .funct3(bus.FUNCT3_i), .funct7_b5(bus.FUNCT7_i[5]),
    .zero(bus.ALU_ZR_i), .alu_op(ac_op), .taken(ac_taken)
  );
  always_comb begin
    state_d    = S_FETCH;
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    pc_source  = PCSRC_ALU;
    src_a      = SRC_A_PC;
    src_b      = SRC_B_RS2;
    alu_op     = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        ir_write = 1'b1;
        pc_write = 1'b1;
        src_b    = SRC_B_FOUR;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        src_a = SRC_A_OLDPC;
        src_b = SRC_B_IMM;
        case (bus.OPCODE_i)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        src_a   = SRC_A_RS1;
        src_b   = SRC_B_IMM;
        state_d = bus.OPCODE_i == OP_STORE ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXECR: begin
        src_a   = SRC_A_RS1;
        alu_op  = ac_op;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        src_a   = SRC_A_RS1;
        src_b   = SRC_B_IMM;
        alu_op  = ac_op;
        state_d = S_ALUWB;
      end
      S_ALUWB: reg_write = 1'b1;
      // branch target was precomputed into ALUOut during DECODE
      S_BRANCH: begin
        src_a     = SRC_A_RS1;
        pc_source = PCSRC_ALUOUT;
        alu_op    = ac_op;
        pc_write  = ac_taken;
      end
      S_JAL: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_ALUOUT;
        src_a     = SRC_A_OLDPC;
        src_b     = SRC_B_FOUR;
        state_d   = S_ALUWB;
      end
      S_JALR: begin
        pc_write = 1'b1;
        src_a    = SRC_A_RS1;
        src_b    = SRC_B_IMM;
        state_d  = S_LINK;
      end
      S_LINK: begin
        src_a   = SRC_A_OLDPC;
        src_b   = SRC_B_FOUR;
        state_d = S_ALUWB;
      end
      S_LUI: begin
        src_a   = SRC_A_ZERO;
        src_b   = SRC_B_IMM;
        state_d = S_ALUWB;
      end
      S_AUIPC: begin
        src_a   = SRC_A_OLDPC;
        src_b   = SRC_B_IMM;
        state_d = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end
  always_ff @(posedge CLK_i) state_q <= RST_i ? S_FETCH : state_d;
  assign bus.PC_WRITE_o   = pc_write & ~RST_i;
  assign bus.MEM_READ_o   = mem_read & ~RST_i;
  assign bus.MEM_WRITE_o  = mem_write & ~RST_i;
  assign bus.IR_WRITE_o   = ir_write & ~RST_i;
  assign bus.REG_WRITE_o  = reg_write & ~RST_i;
  assign bus.IORD_o       = iord;
  assign bus.MEM_TO_REG_o = mem_to_reg;
  assign bus.ALU_SRC_A_o  = src_a;
  assign bus.ALU_SRC_B_o  = src_b;
  assign bus.PC_SOURCE_o  = pc_source;
  assign bus.ALU_OP_o     = alu_op;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed and random instructions checked cycle by cycle against a per-instruction step model
module tb_control_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  control_unit_if bus();
  control_unit dut (.CLK_i(clk), .RST_i(rst), .bus(bus));
  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] q_e[$];
  logic [15:0] q_m[$];
  logic [6:0] ops[9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                         7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
  localparam logic [15:0] STROBES = 16'hBA00;
  wire [15:0] obs = {bus.PC_WRITE_o, bus.IORD_o, bus.MEM_READ_o, bus.MEM_WRITE_o, bus.IR_WRITE_o,
                     bus.MEM_TO_REG_o, bus.REG_WRITE_o, bus.ALU_SRC_A_o, bus.ALU_SRC_B_o,
                     bus.PC_SOURCE_o, bus.ALU_OP_o};
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] mk(input bit pcw, iord, mr, mw, irw, m2r, rw,
                                     input logic [1:0] a, b, input bit ps, input logic [3:0] op);
    return {pcw, iord, mr, mw, irw, m2r, rw, a, b, ps, op};
  endfunction
  function automatic logic [3:0] ref_op(input logic [2:0] f3, input bit f7b5, input bit imm);
    logic [31:0] tab = {4'b0000, 4'b0001, 4'b0101, 4'b1000, 4'b1111, 4'b1110, 4'b0100, 4'b0010};
    if (f3 == 3'd0 && f7b5 && !imm) return 4'b1010;
    if (f3 == 3'd5 && f7b5) return 4'b0111;
    return tab[{f3, 2'b00} +: 4];
  endfunction
  function automatic logic [3:0] br_op(input logic [2:0] f3);
    logic [31:0] tab = {4'b1101, 4'b1111, 4'b1100, 4'b1110, 4'b0000, 4'b0000, 4'b1010, 4'b1010};
    return tab[{f3, 2'b00} +: 4];
  endfunction
  function automatic bit br_taken(input logic [2:0] f3, input bit zr);
    return f3 == 3'd0 ? zr : (f3 == 3'd2 || f3 == 3'd3) ? 1'b0 : !zr;
  endfunction
  task automatic push(input logic [15:0] e, input logic [15:0] m = 16'hFFFF);
    q_e.push_back(e);
    q_m.push_back(m);
  endtask
  task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7, input bit zr);
    logic [15:0] aluwb = mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 4'b0010);
    q_e.delete();
    q_m.delete();
    push(mk(1, 0, 1, 0, 1, 0, 0, 2'b00, 2'b01, 0, 4'b0010));
    push(mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 0, 4'b0010));
    case (op)
      7'b0000011: begin
        push(mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 0, 4'b0010));
        push(mk(0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 4'b0010));
        push(mk(0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 0, 4'b0010));
      end
      7'b0100011: begin
        push(mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 0, 4'b0010));
        push(mk(0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 4'b0010));
      end
      7'b0110011: begin
        push(mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, ref_op(f3, f7[5], 0)));
        push(aluwb);
      end
      7'b0010011: begin
        push(mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 0, ref_op(f3, f7[5], 1)));
        push(aluwb);
      end
      7'b1100011: push(mk(br_taken(f3, zr), 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 1, br_op(f3)),
                       (f3 == 3'd2 || f3 == 3'd3) ? 16'hFFF0 : 16'hFFFF);
      7'b1101111: begin
        push(mk(1, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 1, 4'b0010));
        push(aluwb);
      end
      7'b1100111: begin
        push(mk(1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 0, 4'b0010));
        push(mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 0, 4'b0010));
        push(aluwb);
      end
      7'b0110111: begin
        push(mk(0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b10, 0, 4'b0010));
        push(aluwb);
      end
      7'b0010111: begin
        push(mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 0, 4'b0010));
        push(aluwb);
      end
      default: ;
    endcase
    bus.OPCODE_i = op;
    bus.FUNCT3_i = f3;
    bus.FUNCT7_i = f7;
    bus.ALU_ZR_i = zr;
    for (int i = 0; i < q_e.size(); i++) begin
      @(negedge clk);
      chk($sformatf("op=%b f3=%0d zr=%0d cycle%0d", op, f3, zr, i + 1), obs & q_m[i], q_e[i] & q_m[i]);
      @(posedge clk);
      #1;
    end
  endtask
  task automatic reset_mid_sw();
    bus.OPCODE_i = 7'b0100011;
    bus.FUNCT3_i = 3'd2;
    @(negedge clk);
    chk("sw_rst fetch", obs, mk(1, 0, 1, 0, 1, 0, 0, 2'b00, 2'b01, 0, 4'b0010));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("sw_rst decode", obs, mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 0, 4'b0010));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("sw_rst memadr strobes", obs & STROBES, 16'h0000);
    chk("sw_rst memadr selects", obs & ~STROBES, mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 0, 4'b0010) & ~STROBES);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  initial begin
    bus.OPCODE_i = 7'b0000011;
    bus.FUNCT3_i = '0;
    bus.FUNCT7_i = '0;
    bus.ALU_ZR_i = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("reset strobes", obs & STROBES, 16'h0000);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    run(7'b0110011, 3'd0, 7'b0100000, 1'b0);
    run(7'b0000011, 3'd2, 7'd0, 1'b0);
    run(7'b1100011, 3'd1, 7'd0, 1'b0);
    run(7'b1100011, 3'd1, 7'd0, 1'b1);
    run(7'b1111111, 3'd0, 7'd0, 1'b0);
    run(7'b1100111, 3'd0, 7'd0, 1'b0);
    reset_mid_sw();
    run(7'b0010011, 3'd5, 7'b0100000, 1'b0);
    for (int n = 0; n < 400; n++) begin
      int idx = $urandom_range(0, 9);
      run(idx == 9 ? 7'($urandom) : ops[idx], 3'($urandom), 7'($urandom), 1'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 SHALL have ports as follows (name, direction, width, meaning), clock and reset first:
- CLK_i, in, 1: clock; all state changes on the rising edge.
- RST_i, in, 1: synchronous, active-high reset.
- OPCODE_i, in, 7: instruction opcode field, from the instruction register.
- FUNCT3_i, in, 3: instruction funct3 field.
- FUNCT7_i, in, 7: instruction funct7 field; only bit 5 is used.
- ALU_ZR_i, in, 1: ALU zero flag.
- PC_WRITE_o, out, 1: PC load strobe.
- IORD_o, out, 1: memory address select; 0 = PC, 1 = ALUOut.
- MEM_READ_o, out, 1: memory read strobe.
- MEM_WRITE_o, out, 1: memory write strobe.
- IR_WRITE_o, out, 1: instruction register load strobe.
- MEM_TO_REG_o, out, 1: register writeback source; 0 = ALUOut, 1 = MDR.
- REG_WRITE_o, out, 1: register file write strobe.
- ALU_SRC_A_o, out, 2: ALU A operand; 00 = PC, 01 = RS1, 10 = old PC, 11 = zero.
- ALU_SRC_B_o, out, 2: ALU B operand; 00 = RS2, 01 = constant 4, 10 = immediate.
- PC_SOURCE_o, out, 1: PC load source; 0 = ALU result, 1 = ALUOut.
- ALU_OP_o, out, 4: operation code driven to the ALU.

Function
REQ-003 SHALL implement a multi-cycle RV32I control FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, LINK, LUI, AUIPC.
REQ-004 SHALL drive these defaults in any state that does not override them: all strobes 0, all selects 0, ALU_OP_o = 0010 (ADD).
REQ-005 FETCH SHALL assert MEM_READ_o, IR_WRITE_o and PC_WRITE_o, with A = PC, B = 4, ADD, PC_SOURCE_o = 0; next state DECODE.
REQ-006 DECODE SHALL drive A = old PC, B = imm, ADD (precomputes the branch/jump target into ALUOut).
REQ-007 DECODE SHALL select the next state from OPCODE_i:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECR
- 0010011 -> EXECI
- 1100011 -> BRANCH
- 1101111 -> JAL
- 1100111 -> JALR
- 0110111 -> LUI
- 0010111 -> AUIPC
- any other value -> FETCH (executes as a NOP)
REQ-008 MEMADR SHALL drive A = RS1, B = imm, ADD; next state MEMREAD for a load, MEMWRITE for a store.
REQ-009 MEMREAD SHALL assert MEM_READ_o with IORD_o = 1 and go to MEMWB; MEMWB SHALL assert REG_WRITE_o with MEM_TO_REG_o = 1 and go to FETCH.
REQ-010 MEMWRITE SHALL assert MEM_WRITE_o with IORD_o = 1 and go to FETCH.
REQ-011 EXECR SHALL drive A = RS1, B = RS2 and set ALU_OP_o from funct3 as follows; next state ALUWB:
- 000 -> ADD 0010, or SUB 1010 when funct7[5] = 1
- 001 -> SLL 0100
- 010 -> SLT 1110
- 011 -> SLTU 1111
- 100 -> XOR 1000
- 101 -> SRL 0101, or SRA 0111 when funct7[5] = 1
- 110 -> OR 0001
- 111 -> AND 0000
REQ-012 EXECI SHALL drive A = RS1, B = imm and use the REQ-011 mapping, except funct3 = 000 always gives ADD; next state ALUWB.
REQ-013 ALUWB SHALL assert REG_WRITE_o with MEM_TO_REG_o = 0 and go to FETCH.
REQ-014 BRANCH SHALL drive A = RS1, B = RS2, PC_SOURCE_o = 1, and set ALU_OP_o and the taken condition from funct3; next state FETCH:
- 000 -> SUB, taken when ALU_ZR_i = 1
- 001 -> SUB, taken when ALU_ZR_i = 0
- 100 -> SLT, taken when ALU_ZR_i = 0
- 101 -> GE 1100, taken when ALU_ZR_i = 0
- 110 -> SLTU, taken when ALU_ZR_i = 0
- 111 -> GEU 1101, taken when ALU_ZR_i = 0
- 010 or 011 -> never taken
REQ-015 In BRANCH, PC_WRITE_o SHALL equal the taken condition, combinationally in the same cycle.
REQ-016 JAL SHALL assert PC_WRITE_o with PC_SOURCE_o = 1, and drive A = old PC, B = 4, ADD; next state ALUWB.
REQ-017 JALR SHALL assert PC_WRITE_o with PC_SOURCE_o = 0, and drive A = RS1, B = imm, ADD; next state LINK.
REQ-018 LINK SHALL drive A = old PC, B = 4, ADD; next state ALUWB.
REQ-019 LUI SHALL drive A = zero, B = imm, ADD; AUIPC SHALL drive A = old PC, B = imm, ADD; both go to ALUWB.
REQ-020 Outputs SHALL be combinational from the state register plus OPCODE_i, FUNCT3_i, FUNCT7_i and ALU_ZR_i, with no extra latency.
REQ-021 Cycle counts per instruction SHALL be:

| Instruction | Cycles |
|---|---|
| LW | 5 |
| SW | 4 |
| R-type | 4 |
| I-type | 4 |
| Branch | 3 |
| JAL | 4 |
| JALR | 5 |
| LUI | 4 |
| AUIPC | 4 |
| Unknown opcode | 2 |

Reset
REQ-022 While RST_i = 1, all strobe outputs SHALL be 0 combinationally, and the state SHALL become FETCH at the clock edge.
REQ-023 A reset asserted mid-instruction SHALL abandon that instruction with no further REG_WRITE_o or MEM_WRITE_o.
REQ-024 On the first cycle after reset is released, the state SHALL be FETCH.

Structure
REQ-025 Shared package control_pkg SHALL hold the ALU_OP codes, the opcode constants, the state enumeration and the source-select encodings.
REQ-026 The funct3/funct7-to-ALU_OP decode SHALL be a sub-module alu_control, used by EXECR, EXECI and BRANCH.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Reset:
  - Stimulus: RST_i held high for 2 cycles, then released.
  - Required: first post-reset cycle is FETCH with MEM_READ_o = 1, IR_WRITE_o = 1, PC_WRITE_o = 1, ALU_OP_o = 0010.
- SUB:
  - Stimulus: OPCODE_i = 0110011, funct3 = 000, funct7 = 0100000.
  - Required: ALU_OP_o = 1010 in EXECR, REG_WRITE_o = 1 in cycle 4, back to FETCH in cycle 5.
- LW:
  - Stimulus: OPCODE_i = 0000011.
  - Required: IORD_o = 1 with MEM_READ_o = 1 in cycle 4; REG_WRITE_o = 1 with MEM_TO_REG_o = 1 in cycle 5.
- BNE:
  - Stimulus: funct3 = 001, once with ALU_ZR_i = 0 and once with ALU_ZR_i = 1.
  - Required: PC_WRITE_o = 1 and 0 respectively in cycle 3, PC_SOURCE_o = 1 in both.
- Unknown opcode and JALR:
  - Stimulus: OPCODE_i = 1111111, then JALR.
  - Required: 1111111 returns to FETCH after DECODE with no strobes; JALR passes FETCH-DECODE-JALR-LINK-ALUWB.
- Reset mid-instruction:
  - Stimulus: RST_i asserted during MEMADR of a SW.
  - Required: MEM_WRITE_o never asserted; next state FETCH.
